// File: rtl/uart_fifo_bridge_pkg.sv
// Shared types and constants for the UART FIFO bridge: TX FSM encoding,
// the UART "no data" read value and the byte width.
package uart_fifo_bridge_pkg;

  localparam int BYTE_W = 8;

  localparam logic [31:0] UART_NO_DATA = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/bridge_sync_fifo.sv
// Single-clock FIFO with an occupancy counter that runs 0..DEPTH; full and
// empty are decoded from the registered level. DEPTH must be a power of two.
module bridge_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level define
  // what is valid, and a reset on the array would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU <-> UART data-register bridge with TX and RX FIFOs. Optional sticky
// overflow flags are built when UART_FIFO_BRIDGE_OVF_EN is defined.
module uart_fifo_bridge
  import uart_fifo_bridge_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        tx_we,
  input  logic [7:0]                  tx_di,
  output logic                        tx_full,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  input  logic                        rx_re,
  output logic [31:0]                 rx_do,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic                        uart_dat_we,
  output logic [31:0]                 uart_dat_di,
  input  logic                        uart_dat_wait,
  output logic                        uart_dat_re,
  input  logic [31:0]                 uart_dat_do,
  output logic [1:0]                  ovf_flags,
  input  logic                        ovf_clr
);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [BYTE_W-1:0] hold;
  logic [BYTE_W-1:0] tx_head;
  logic              tx_empty;
  logic              tx_pop;

  logic [BYTE_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;

  bridge_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (tx_we),
    .din    (tx_di),
    .pop    (tx_pop),
    .full   (tx_full),
    .empty  (tx_empty),
    .level  (tx_level),
    .head   (tx_head)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!tx_empty)      state_next = SEND;
      SEND:    if (!uart_dat_wait) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_pop      = 1'b0;
    uart_dat_we = 1'b0;
    case (state)
      IDLE:    tx_pop      = !tx_empty;
      SEND:    uart_dat_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     hold <= '0;
    else if (tx_pop) hold <= tx_head;
  end

  assign uart_dat_di = {{(32-BYTE_W){1'b0}}, hold};

  // Drain the UART's single receive slot whenever there is room downstream.
  assign uart_dat_re = (uart_dat_do != UART_NO_DATA) && !rx_full;

  bridge_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (uart_dat_re),
    .din    (uart_dat_do[BYTE_W-1:0]),
    .pop    (rx_re),
    .full   (rx_full),
    .empty  (rx_empty),
    .level  (rx_level),
    .head   (rx_head)
  );

  assign rx_do = rx_empty ? UART_NO_DATA : {{(32-BYTE_W){1'b0}}, rx_head};

`ifdef UART_FIFO_BRIDGE_OVF_EN
  logic [1:0] ovf_set;

  assign ovf_set = {rx_re && rx_empty, tx_we && tx_full};

  // A new event in the same cycle as a clear survives the clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovf_flags <= '0;
    else         ovf_flags <= (ovf_clr ? 2'b00 : ovf_flags) | ovf_set;
  end
`else
  // Flags are constant zero; ovf_clr is referenced only to keep the port live.
  assign ovf_flags = {2{ovf_clr}} & 2'b00;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed self-checking bench for uart_fifo_bridge (default 16-entry FIFOs).
module tb_uart_fifo_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tx_we;
  logic [7:0]  tx_di;
  logic        tx_full;
  logic [4:0]  tx_level;
  logic        rx_re;
  logic [31:0] rx_do;
  logic [4:0]  rx_level;
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
  logic        uart_dat_wait;
  logic        uart_dat_re;
  logic [31:0] uart_dat_do;
  logic [1:0]  ovf_flags;
  logic        ovf_clr;

  int checks = 0;
  int errors = 0;

  uart_fifo_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .tx_we         (tx_we),
    .tx_di         (tx_di),
    .tx_full       (tx_full),
    .tx_level      (tx_level),
    .rx_re         (rx_re),
    .rx_do         (rx_do),
    .rx_level      (rx_level),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait),
    .uart_dat_re   (uart_dat_re),
    .uart_dat_do   (uart_dat_do),
    .ovf_flags     (ovf_flags),
    .ovf_clr       (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef UART_FIFO_BRIDGE_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic [7:0] sent [$];
  int         sends;

  initial begin
    resetn        = 1'b0;
    tx_we         = 1'b0;
    tx_di         = 8'h00;
    rx_re         = 1'b0;
    uart_dat_wait = 1'b0;
    uart_dat_do   = 32'hFFFF_FFFF;
    ovf_clr       = 1'b0;

    // Reset state
    #1;
    check("rst_tx_full",  tx_full,     0);
    check("rst_tx_level", tx_level,    0);
    check("rst_rx_level", rx_level,    0);
    check("rst_rx_do",    rx_do,       32'hFFFF_FFFF);
    check("rst_we",       uart_dat_we, 0);
    check("rst_re",       uart_dat_re, 0);
    check("rst_di",       uart_dat_di, 0);
    check("rst_ovf",      ovf_flags,   0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // 1: single byte, latency 2 clocks, one-cycle write
    tx_we = 1'b1; tx_di = 8'h41;
    tick();
    tx_we = 1'b0;
    check("t1_we_c1",    uart_dat_we, 0);
    check("t1_level_c1", tx_level,    1);
    tick();
    check("t1_we_c2",    uart_dat_we, 1);
    check("t1_di_c2",    uart_dat_di, 32'h41);
    check("t1_level_c2", tx_level,    0);
    tick();
    check("t1_we_c3",    uart_dat_we, 0);

    // 2: burst with UART stalled, fill, overflow, drain in order
    uart_dat_wait = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tx_we = 1'b1; tx_di = 8'(i);
      tick();
      if (i == 15) begin
        check("t2_level_16w", tx_level,    15);
        check("t2_full_16w",  tx_full,     0);
        check("t2_we_held",   uart_dat_we, 1);
        check("t2_di_held",   uart_dat_di, 32'h00);
      end
    end
    check("t2_level_17w", tx_level, 16);
    check("t2_full_17w",  tx_full,  1);
    tx_di = 8'hEE;
    tick();
    tx_we = 1'b0;
    check("t2_level_drop", tx_level,     16);
    check("t2_ovf_tx",     ovf_flags[0], OVF_ON);
    uart_dat_wait = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (uart_dat_we) sent.push_back(uart_dat_di[7:0]);
      tick();
    end
    check("t2_sent_count", sent.size(), 17);
    for (int i = 0; i < sent.size() && i < 17; i++)
      check($sformatf("t2_sent_%0d", i), sent[i], i);
    check("t2_level_end", tx_level, 0);
    check("t2_full_end",  tx_full,  0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t2_ovf_clr", ovf_flags, 0);

    // 3: one received byte, then CPU read
    uart_dat_do = 32'h5A;
    #1;
    check("t3_re_comb", uart_dat_re, 1);
    tick();
    uart_dat_do = 32'hFFFF_FFFF;
    #1;
    check("t3_re_off",  uart_dat_re, 0);
    check("t3_level",   rx_level,    1);
    check("t3_rx_do",   rx_do,       32'h5A);
    rx_re = 1'b1;
    tick();
    rx_re = 1'b0;
    check("t3_rx_do_empty", rx_do,    32'hFFFF_FFFF);
    check("t3_level_empty", rx_level, 0);

    // 4: fill RX FIFO, back-pressure on UART, then one pop admits 0x33
    for (int i = 0; i < 16; i++) begin
      uart_dat_do = 32'hA0 + i;
      tick();
    end
    uart_dat_do = 32'h33;
    #1;
    check("t4_level_full", rx_level,    16);
    check("t4_re_blocked", uart_dat_re, 0);
    check("t4_head",       rx_do,       32'hA0);
    tick();
    check("t4_re_blocked2", uart_dat_re, 0);
    check("t4_level_hold",  rx_level,    16);
    rx_re = 1'b1;
    tick();
    rx_re = 1'b0;
    check("t4_re_after_pop", uart_dat_re, 1);
    check("t4_level_15",     rx_level,    15);
    check("t4_head_a1",      rx_do,       32'hA1);
    tick();
    uart_dat_do = 32'hFFFF_FFFF;
    #1;
    check("t4_level_refill", rx_level, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_drain_%0d", i), rx_do, (i < 15) ? 32'hA1 + i : 32'h33);
      rx_re = 1'b1;
      tick();
    end
    rx_re = 1'b0;
    check("t4_level_drained", rx_level, 0);

    // 5: simultaneous push/pop at level 1, then read while empty
    uart_dat_do = 32'h11;
    tick();
    uart_dat_do = 32'h22;
    rx_re = 1'b1;
    tick();
    uart_dat_do = 32'hFFFF_FFFF;
    rx_re = 1'b0;
    check("t5_level_same", rx_level, 1);
    check("t5_head_adv",   rx_do,    32'h22);
    rx_re = 1'b1;
    tick();
    check("t5_level_0", rx_level, 0);
    tick();
    rx_re = 1'b0;
    check("t5_level_ign", rx_level,     0);
    check("t5_rx_do_ign", rx_do,        32'hFFFF_FFFF);
    check("t5_ovf_rx",    ovf_flags[1], OVF_ON);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t5_ovf_clr", ovf_flags, 0);

    // 6: async reset in the middle of SEND
    uart_dat_wait = 1'b1;
    tx_we = 1'b1; tx_di = 8'h77;
    tick();
    tx_di = 8'h78;
    tick();
    tx_we = 1'b0;
    check("t6_we_send",  uart_dat_we, 1);
    check("t6_di_send",  uart_dat_di, 32'h77);
    check("t6_level_1",  tx_level,    1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_we_async",    uart_dat_we, 0);
    check("t6_di_async",    uart_dat_di, 0);
    check("t6_level_async", tx_level,    0);
    check("t6_rxlvl_async", rx_level,    0);
    tick();
    resetn = 1'b1;
    uart_dat_wait = 1'b0;
    sends = 0;
    for (int c = 0; c < 12; c++) begin
      if (uart_dat_we) sends++;
      tick();
    end
    check("t6_no_resend", sends, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
